// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Shared-bus arbiter for MASTER_CH masters. Active-low requests are
// arbitrated into a registered, one-hot active-low grant. The arbitration
// policy is round-robin (PRIO_MODE = 0) or fixed priority with master 0
// highest (PRIO_MODE = 1). A granted master keeps the bus until it releases
// its request. There is no preemption.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   When defined, a watchdog counts stalled cycles (address strobe asserted,
//   slave not ready). After TIMEOUT_CYC such cycles it revokes the grant and
//   pulses bus_err. When undefined, no counter is built and bus_err is 0.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous active-high reset
//   req_     in   [MASTER_CH]  per-master bus request, active low
//   s_as_    in   address strobe of the current owner (post-mux), active low
//   s_rdy_   in   slave ready (post-mux), active low
//   grnt_    out  [MASTER_CH]  one-hot active-low grant, registered
//   owner    out  [OWNER_W]    index of granted master, holds last when idle
//   busy     out  high while any grant is active
//   bus_err  out  one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int MASTER_CH   = 4,
    parameter int PRIO_MODE   = 0,
    parameter int TIMEOUT_CYC = 255,
    localparam int OWNER_W    = (MASTER_CH > 1) ? $clog2(MASTER_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MASTER_CH-1:0] req_,
    input  logic                 s_as_,
    input  logic                 s_rdy_,
    output logic [MASTER_CH-1:0] grnt_,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 bus_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [MASTER_CH-1:0] grnt_q, grnt_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic                 busy_q, busy_d;

    logic [MASTER_CH-1:0] req_act;
    logic [OWNER_W-1:0]   winner;

    // Winner among active-high requests. Round-robin searches upward from
    // the index after ptr and wraps; fixed priority takes the lowest index.
    function automatic logic [OWNER_W-1:0] pick(
        input logic [MASTER_CH-1:0] req,
        input logic [OWNER_W-1:0]   ptr
    );
        logic [OWNER_W-1:0] win;
        logic               found;
        win   = '0;
        found = 1'b0;
        if (PRIO_MODE != 0) begin
            for (int j = 0; j < MASTER_CH; j++) begin
                if (!found && req[j]) begin
                    win   = OWNER_W'(j);
                    found = 1'b1;
                end
            end
        end else begin
            // First pass: indices above the pointer.
            for (int j = 0; j < MASTER_CH; j++) begin
                if (!found && req[j] && (j > int'(ptr))) begin
                    win   = OWNER_W'(j);
                    found = 1'b1;
                end
            end
            // Second pass: wrap around to indices at or below the pointer.
            for (int j = 0; j < MASTER_CH; j++) begin
                if (!found && req[j] && (j <= int'(ptr))) begin
                    win   = OWNER_W'(j);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    assign req_act = ~req_;
    assign winner  = pick(req_act, ptr_q);

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        stall;

    assign stall = (state_q == GRANT) && !s_as_ && s_rdy_;
`endif

    always_comb begin
        state_d = state_q;
        grnt_d  = grnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        wd_cnt_d  = '0;
        bus_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (|req_act) begin
                    grnt_d  = ~({{(MASTER_CH-1){1'b0}}, 1'b1} << winner);
                    owner_d = winner;
                    ptr_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // The owner is never preempted; only its release moves the bus.
                if (!req_act[owner_q]) begin
                    if (|req_act) begin
                        grnt_d  = ~({{(MASTER_CH-1){1'b0}}, 1'b1} << winner);
                        owner_d = winner;
                        ptr_d   = winner;
                    end else begin
                        grnt_d  = '1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grnt_d  = '1;
                state_d = IDLE;
            end
        endcase

`ifdef BUS_ARB_TIMEOUT_EN
        // The count reaches TIMEOUT_CYC on the edge closing the Nth
        // consecutive stalled cycle. A ready slave in that cycle breaks the
        // stall, so ready always beats the watchdog.
        if (stall) begin
            if (wd_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                grnt_d    = '1;
                owner_d   = owner_q;
                ptr_d     = owner_q;
                state_d   = IDLE;
                bus_err_d = 1'b1;
                wd_cnt_d  = '0;
            end else if (grnt_d == grnt_q) begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end
`endif

        busy_d = |(~grnt_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grnt_q  <= '1;
            owner_q <= '0;
            ptr_q   <= OWNER_W'(MASTER_CH - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grnt_q  <= grnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    // Bus status inputs and the timeout limit have no function without the
    // watchdog.
    logic unused_wd;
    assign unused_wd = ^{s_as_, s_rdy_, 16'(TIMEOUT_CYC)};
    assign bus_err   = 1'b0;
`endif

    assign grnt_ = grnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    typedef struct packed {
        logic [3:0] grnt;
        logic [1:0] owner;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req_rr, req_fp;
    logic [1:0] req2;
    logic       s_as_, s_rdy_;

    logic [3:0] grnt_rr, grnt_fp;
    logic [1:0] owner_rr, owner_fp;
    logic       busy_rr, busy_fp, err_rr, err_fp;
    logic [1:0] grnt2;
    logic       owner2, busy2, err2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    bus_arbiter_rr #(.MASTER_CH(4), .PRIO_MODE(0), .TIMEOUT_CYC(8)) u_rr (
        .clk(clk), .reset(reset), .req_(req_rr), .s_as_(s_as_), .s_rdy_(s_rdy_),
        .grnt_(grnt_rr), .owner(owner_rr), .busy(busy_rr), .bus_err(err_rr)
    );

    bus_arbiter_rr #(.MASTER_CH(4), .PRIO_MODE(1), .TIMEOUT_CYC(8)) u_fp (
        .clk(clk), .reset(reset), .req_(req_fp), .s_as_(s_as_), .s_rdy_(s_rdy_),
        .grnt_(grnt_fp), .owner(owner_fp), .busy(busy_fp), .bus_err(err_fp)
    );

    bus_arbiter_rr #(.MASTER_CH(2), .PRIO_MODE(0), .TIMEOUT_CYC(8)) u_m2 (
        .clk(clk), .reset(reset), .req_(req2), .s_as_(s_as_), .s_rdy_(s_rdy_),
        .grnt_(grnt2), .owner(owner2), .busy(busy2), .bus_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs,
    // then pop and compare after the edge.
    task automatic step(input bit fp, input logic [3:0] req, input logic as_n,
                        input logic rdy_n, input logic [3:0] eg, input logic [1:0] eo,
                        input logic eb, input logic ee, input string tag);
        exp_t e;
        exp_t got;
        if (fp) begin
            req_fp = req;
            req_rr = 4'hF;
        end else begin
            req_rr = req;
            req_fp = 4'hF;
        end
        s_as_  = as_n;
        s_rdy_ = rdy_n;
        sb_q.push_back({eg, eo, eb, ee});
        @(posedge clk);
        #1;
        got = fp ? {grnt_fp, owner_fp, busy_fp, err_fp} : {grnt_rr, owner_rr, busy_rr, err_rr};
        e = sb_q.pop_front();
        check(tag, got, e);
    endtask

    task automatic check_now(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                             input logic eb, input logic ee);
        exp_t e;
        sb_q.push_back({eg, eo, eb, ee});
        e = sb_q.pop_front();
        check({tag, "_rr"}, {grnt_rr, owner_rr, busy_rr, err_rr}, e);
        check({tag, "_fp"}, {grnt_fp, owner_fp, busy_fp, err_fp}, e);
    endtask

    task automatic step2(input logic [1:0] req, input logic [1:0] eg, input logic eo,
                         input logic eb, input string tag);
        req2 = req;
        @(posedge clk);
        #1;
        check(tag, {3'b0, grnt2, owner2, busy2, err2}, {3'b0, eg, eo, eb, 1'b0});
    endtask

    // At most one grant low at any time, checked away from the active edge.
    always @(negedge clk) begin
        check("onehot_rr", 8'($onehot0(~grnt_rr)), 8'd1);
        check("onehot_fp", 8'($onehot0(~grnt_fp)), 8'd1);
    end

    initial begin
        reset  = 1'b1;
        req_rr = 4'hF;
        req_fp = 4'hF;
        req2   = 2'b11;
        s_as_  = 1'b1;
        s_rdy_ = 1'b1;
        #12;
        check_now("reset_vals", 4'hF, 2'd0, 1'b0, 1'b0);
        check("reset_m2", {3'b0, grnt2, owner2, busy2, err2}, {3'b0, 2'b11, 1'b0, 1'b0, 1'b0});

        // Reset release with master 0 requesting.
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 1, 0, "rst_rel_grant0");
        step(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "release_idle");

        // Fresh reset so round-robin starts at master 0.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step(0, 4'b0000, 1, 1, 4'b1110, 2'd0, 1, 0, "rr_g0");
        for (int k = 0; k < 2; k++) step(0, 4'b0000, 1, 1, 4'b1110, 2'd0, 1, 0, "rr_hold0");
        step(0, 4'b0001, 1, 1, 4'b1101, 2'd1, 1, 0, "rr_g1");
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 1, 1, 4'b1101, 2'd1, 1, 0, "rr_hold1");
        step(0, 4'b0010, 1, 1, 4'b1011, 2'd2, 1, 0, "rr_g2");
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 1, 1, 4'b1011, 2'd2, 1, 0, "rr_hold2");
        step(0, 4'b0100, 1, 1, 4'b0111, 2'd3, 1, 0, "rr_g3");
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 1, 1, 4'b0111, 2'd3, 1, 0, "rr_hold3");
        step(0, 4'b1000, 1, 1, 4'b1110, 2'd0, 1, 0, "rr_wrap_g0");
        step(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "rr_idle_owner_held");

        // Reset in the middle of a transfer owned by master 3.
        step(0, 4'b0111, 1, 1, 4'b0111, 2'd3, 1, 0, "mid_own3");
        #2;
        reset = 1'b1;
        #1;
        check_now("rst_mid_async", 4'hF, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("rst_mid_held", 4'hF, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(0, 4'b0111, 1, 1, 4'b0111, 2'd3, 1, 0, "rst_mid_regrant3");
        step(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0, 0, "idle_owner3");

        // Two-master instance: pointer wraps 1 -> 0.
        step2(2'b00, 2'b10, 1'b0, 1'b1, "m2_g0");
        step2(2'b01, 2'b01, 1'b1, 1'b1, "m2_g1");
        step2(2'b10, 2'b10, 1'b0, 1'b1, "m2_wrap_g0");
        step2(2'b11, 2'b11, 1'b0, 1'b0, "m2_idle");

        // Fixed priority: no preemption of the owner, lowest index wins next.
        step(1, 4'b1011, 1, 1, 4'b1011, 2'd2, 1, 0, "fp_own2");
        step(1, 4'b0001, 1, 1, 4'b1011, 2'd2, 1, 0, "fp_no_preempt_a");
        step(1, 4'b0001, 1, 1, 4'b1011, 2'd2, 1, 0, "fp_no_preempt_b");
        step(1, 4'b0101, 1, 1, 4'b1101, 2'd1, 1, 0, "fp_m1_wins");
        step(1, 4'b0101, 1, 1, 4'b1101, 2'd1, 1, 0, "fp_hold1");
        step(1, 4'b0111, 1, 1, 4'b0111, 2'd3, 1, 0, "fp_m3");
        step(1, 4'b0110, 1, 1, 4'b0111, 2'd3, 1, 0, "fp_m3_keeps");
        step(1, 4'b1110, 1, 1, 4'b1110, 2'd0, 1, 0, "fp_m0");
        step(1, 4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "fp_idle");

`ifdef BUS_ARB_TIMEOUT_EN
        // Watchdog fires on the 8th stalled cycle; pending master 2 follows.
        step(0, 4'b1101, 1, 1, 4'b1101, 2'd1, 1, 0, "wd_grant1");
        for (int k = 0; k < 7; k++) step(0, 4'b1001, 0, 1, 4'b1101, 2'd1, 1, 0, "wd_stall");
        step(0, 4'b1001, 0, 1, 4'b1111, 2'd1, 0, 1, "wd_fire");
        step(0, 4'b1001, 1, 1, 4'b1011, 2'd2, 1, 0, "wd_next2");
        // Ready in the cycle the count would hit the limit wins.
        for (int k = 0; k < 7; k++) step(0, 4'b1011, 0, 1, 4'b1011, 2'd2, 1, 0, "race_stall");
        step(0, 4'b1011, 0, 0, 4'b1011, 2'd2, 1, 0, "race_rdy_wins");
        for (int k = 0; k < 7; k++) step(0, 4'b1011, 0, 1, 4'b1011, 2'd2, 1, 0, "race_restall");
        step(0, 4'b1011, 0, 1, 4'b1111, 2'd2, 0, 1, "race_refire");
        step(0, 4'b1111, 1, 1, 4'b1111, 2'd2, 0, 0, "wd_idle");
`else
        // Without the watchdog a stalled grant is held indefinitely.
        step(0, 4'b1101, 1, 1, 4'b1101, 2'd1, 1, 0, "stall_grant1");
        for (int k = 0; k < 1000; k++) step(0, 4'b1101, 0, 1, 4'b1101, 2'd1, 1, 0, "stall_hold");
        step(0, 4'b1111, 1, 1, 4'b1111, 2'd1, 0, 0, "stall_release");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
